// File: rtl/snake_pkg.sv
// Shared snake-game constants, default item position and placer state encoding.
package snake_pkg;

    localparam int XSIZE    = 48;
    localparam int YSIZE    = 64;
    localparam int MAX_SIZE = 20;
    localparam int COORD_W  = 6;

    localparam logic [COORD_W-1:0] ITEM_X0 = COORD_W'(XSIZE >> 2);
    localparam logic [COORD_W-1:0] ITEM_Y0 = COORD_W'(YSIZE >> 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/item_placer_if.sv
// Request/response bundle between the game controller and the item placer.
interface item_placer_if #(
    parameter int MAX_SIZE = snake_pkg::MAX_SIZE
);
    import snake_pkg::*;

    logic [MAX_SIZE*COORD_W-1:0] body_x;
    logic [MAX_SIZE*COORD_W-1:0] body_y;
    logic [11:0]                 size;
    logic                        start;
    logic [COORD_W-1:0]          item_x;
    logic [COORD_W-1:0]          item_y;
    logic                        done;
    logic                        busy;

    modport master (
        output body_x, body_y, size, start,
        input  item_x, item_y, done, busy
    );

    modport slave (
        input  body_x, body_y, size, start,
        output item_x, item_y, done, busy
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic [15:0] o_Value
);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Value <= SEED;
        end else begin
            o_Value <= {o_Value[0] ^ o_Value[2] ^ o_Value[3] ^ o_Value[5], o_Value[15:1]};
        end
    end

endmodule

// File: rtl/item_placer.sv
// Picks a wall-free, body-free cell: random LFSR draws, then a raster scan once
// the random-try budget is spent, checking one body segment per cycle.
module item_placer #(
    parameter int          XSIZE     = snake_pkg::XSIZE,
    parameter int          YSIZE     = snake_pkg::YSIZE,
    parameter int          MAX_SIZE  = snake_pkg::MAX_SIZE,
    parameter int          MAX_TRIES = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    item_placer_if.slave bus
);
    import snake_pkg::*;

    localparam int CNT_W = $clog2(MAX_SIZE + 1);
    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(XSIZE - 2);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(YSIZE - 2);
    localparam logic [COORD_W-1:0] RST_X   = COORD_W'(XSIZE >> 2);
    localparam logic [COORD_W-1:0] RST_Y   = COORD_W'(YSIZE >> 1);
    localparam logic [15:0]        TRY_LIM = 16'(MAX_TRIES);

    logic [15:0] lfsr_value;
    logic        unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .o_Value (lfsr_value)
    );

    assign unused_lfsr = ^lfsr_value[15:12];

    state_e             state;
    logic [COORD_W-1:0] snap_x [MAX_SIZE];
    logic [COORD_W-1:0] snap_y [MAX_SIZE];
    logic [CNT_W-1:0]   n, idx, n_next;
    logic [15:0]        tries;
    logic               fb;
    logic [COORD_W-1:0] cand_x, cand_y, item_x, item_y;
    logic               done, busy;

    logic               fb_mode, draw_ok, hit;
    logic [COORD_W-1:0] draw_x, draw_y, rx, ry;

    assign rx      = lfsr_value[5:0];
    assign ry      = lfsr_value[11:6];
    assign fb_mode = fb || (tries >= TRY_LIM);
    assign hit     = (snap_x[idx] == cand_x) && (snap_y[idx] == cand_y);
    assign n_next  = (bus.size > 12'(MAX_SIZE)) ? CNT_W'(MAX_SIZE) : bus.size[CNT_W-1:0];

    // The first fallback draw lands on (1,1); later ones step the raster from the previous candidate.
    always_comb begin
        draw_x  = rx;
        draw_y  = ry;
        draw_ok = (rx >= 6'd1) && (rx <= X_MAX) && (ry >= 6'd1) && (ry <= Y_MAX);
        if (fb_mode) begin
            draw_ok = 1'b1;
            if (!fb) begin
                draw_x = 6'd1;
                draw_y = 6'd1;
            end else if (cand_x == X_MAX) begin
                draw_x = 6'd1;
                draw_y = (cand_y == Y_MAX) ? 6'd1 : cand_y + 6'd1;
            end else begin
                draw_x = cand_x + 6'd1;
                draw_y = cand_y;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state  <= IDLE;
            n      <= '0;
            idx    <= '0;
            tries  <= '0;
            fb     <= 1'b0;
            cand_x <= '0;
            cand_y <= '0;
            item_x <= RST_X;
            item_y <= RST_Y;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (bus.start) begin
                        for (int unsigned k = 0; k < MAX_SIZE; k++) begin
                            snap_x[k] <= bus.body_x[k*COORD_W +: COORD_W];
                            snap_y[k] <= bus.body_y[k*COORD_W +: COORD_W];
                        end
                        n     <= n_next;
                        tries <= '0;
                        fb    <= 1'b0;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (draw_ok) begin
                        cand_x <= draw_x;
                        cand_y <= draw_y;
                        fb     <= fb_mode;
                        idx    <= '0;
                        if (n == '0) begin
                            item_x <= draw_x;
                            item_y <= draw_y;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CHECK;
                        end
                    end else if (tries != 16'hFFFF) begin
                        tries <= tries + 16'd1;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        if (tries != 16'hFFFF) tries <= tries + 16'd1;
                        state <= DRAW;
                    end else if (idx == n - 1'b1) begin
                        item_x <= cand_x;
                        item_y <= cand_y;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.item_x = item_x;
    assign bus.item_y = item_y;
    assign bus.done   = done;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_item_placer.sv
// Bench for item_placer: table of raster-fallback vectors plus randomized
// starts checked against a draw-by-draw cost model of the placement rules.
module tb_item_placer;
    import snake_pkg::*;

    localparam int MS = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    item_placer_if #(.MAX_SIZE(MS)) bus1 ();
    item_placer_if #(.MAX_SIZE(MS)) bus2 ();

    item_placer #(
        .XSIZE(48), .YSIZE(64), .MAX_SIZE(MS), .MAX_TRIES(64), .LFSR_SEED(16'hACE1)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus1.slave)
    );

    item_placer #(
        .XSIZE(8), .YSIZE(4), .MAX_SIZE(MS), .MAX_TRIES(0), .LFSR_SEED(16'h1234)
    ) dut_fb (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus2.slave)
    );

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // LFSR value the main DUT holds during the current cycle
    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : step(m_lfsr);

    int bx1 [MS];
    int by1 [MS];

    function automatic bit in_board(input int x, input int y);
        return (x >= 1) && (x <= 46) && (y >= 1) && (y <= 62);
    endfunction

    function automatic int body_hit(input int x, input int y, input int n);
        for (int i = 0; i < n; i++)
            if (bx1[i] == x && by1[i] == y) return i;
        return -1;
    endfunction

    // Walk draws by their cycle cost; l_now is the LFSR during the start cycle.
    task automatic predict(input logic [15:0] l_now, input int n,
                           output int ex, output int ey, output int lat);
        logic [15:0] l;
        int t, tries, k, cx, cy, h;
        l = step(l_now); t = 1; tries = 0; k = 0;
        ex = -1; ey = -1; lat = -1;
        for (int guard = 0; guard < 20000; guard++) begin
            if (tries >= 64) begin
                cx = 1 + (k % 46); cy = 1 + ((k / 46) % 62); k++;
            end else begin
                cx = int'(l[5:0]); cy = int'(l[11:6]);
                if (!in_board(cx, cy)) begin
                    tries++; l = step(l); t++;
                    continue;
                end
            end
            h = body_hit(cx, cy, n);
            if (h < 0) begin
                ex = cx; ey = cy; lat = t + n + 1;
                return;
            end
            for (int c = 0; c < h + 2; c++) l = step(l);
            t += h + 2;
            tries++;
        end
    endtask

    task automatic pack1();
        for (int i = 0; i < MS; i++) begin
            bus1.body_x[i*6 +: 6] = 6'(bx1[i]);
            bus1.body_y[i*6 +: 6] = 6'(by1[i]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic op1(input string tag, input int size,
                       output int lat, output int ox, output int oy);
        int n, ex, ey, elat, k;
        n = (size > MS) ? MS : size;
        bus1.size = 12'(size);
        pack1();
        predict(m_lfsr, n, ex, ey, elat);
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        k = 1;
        while (!bus1.done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done seen"}, int'(bus1.done), 1);
        lat = k; ox = int'(bus1.item_x); oy = int'(bus1.item_y);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " item_x"}, ox, ex);
        chk({tag, " item_y"}, oy, ey);
        @(negedge clk);
        chk({tag, " done width"}, int'(bus1.done), 0);
    endtask

    typedef struct {
        int size;
        int bx [6];
        int by [6];
        int fx, fy;
        int ex, ey, lat;
    } vec_t;

    vec_t vecs [7];

    task automatic op2(input int vi);
        int k;
        for (int i = 0; i < MS; i++) begin
            bus2.body_x[i*6 +: 6] = 6'((i < 6) ? vecs[vi].bx[i] : vecs[vi].fx);
            bus2.body_y[i*6 +: 6] = 6'((i < 6) ? vecs[vi].by[i] : vecs[vi].fy);
        end
        bus2.size  = 12'(vecs[vi].size);
        bus2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.start = 1'b0;
        k = 1;
        while (!bus2.done && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("fb%0d latency", vi), k, vecs[vi].lat);
        chk($sformatf("fb%0d item_x", vi), int'(bus2.item_x), vecs[vi].ex);
        chk($sformatf("fb%0d item_y", vi), int'(bus2.item_y), vecs[vi].ey);
        @(negedge clk);
    endtask

    initial begin
        int lat, ox, oy, cx, cy, n, dcount, bad;
        logic [15:0] c;

        vecs[0] = '{3,  '{1,2,3,0,0,0}, '{1,1,1,0,0,0}, 0, 0, 4, 1, 14};
        vecs[1] = '{0,  '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 0, 0, 1, 1, 2};
        vecs[2] = '{2,  '{5,1,0,0,0,0}, '{5,1,0,0,0,0}, 0, 0, 2, 1, 7};
        vecs[3] = '{6,  '{1,2,3,4,5,6}, '{1,1,1,1,1,1}, 0, 0, 1, 2, 35};
        vecs[4] = '{25, '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 1, 1, 2, 1, 30};
        vecs[5] = '{5,  '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 1, 1, 1, 1, 7};
        vecs[6] = '{7,  '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 1, 1, 2, 1, 17};

        bus1.start = 1'b0; bus1.size = '0; bus1.body_x = '0; bus1.body_y = '0;
        bus2.start = 1'b0; bus2.size = '0; bus2.body_x = '0; bus2.body_y = '0;
        for (int i = 0; i < MS; i++) begin bx1[i] = 0; by1[i] = 0; end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset item_x", int'(bus1.item_x), 12);
        chk("reset item_y", int'(bus1.item_y), 32);
        chk("reset done", int'(bus1.done), 0);
        chk("reset busy", int'(bus1.busy), 0);
        chk("reset lfsr", int'(dut.lfsr_value), 16'hACE1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("lfsr first step", int'(dut.lfsr_value), 16'h5670);

        for (int vi = 0; vi < 7; vi++) op2(vi);

        // Direct hit: wait for an in-range, off-body first draw
        bx1[0] = 24; by1[0] = 32; bx1[1] = 24; by1[1] = 33; bx1[2] = 24; by1[2] = 34;
        for (int g = 0; g < 2000; g++) begin
            c = step(m_lfsr);
            if (in_board(int'(c[5:0]), int'(c[11:6])) && body_hit(int'(c[5:0]), int'(c[11:6]), 3) < 0) break;
            @(negedge clk);
        end
        op1("direct", 3, lat, ox, oy);
        chk("direct five cycles", lat, 5);

        // Body collision: first in-range draw sits on segment 1
        for (int g = 0; g < 2000; g++) begin
            c = step(m_lfsr);
            if (in_board(int'(c[5:0]), int'(c[11:6]))) break;
            @(negedge clk);
        end
        cx = int'(c[5:0]); cy = int'(c[11:6]);
        bx1[0] = 0; by1[0] = 0; bx1[1] = cx; by1[1] = cy; bx1[2] = 0; by1[2] = 1;
        op1("collide", 3, lat, ox, oy);
        chk("collide rejected", int'(ox == cx && oy == cy), 0);
        chk("collide slower", int'(lat > 5), 1);

        op1("empty", 0, lat, ox, oy);
        chk("empty two cycles", lat, 2);

        // Second start while busy must be ignored
        bx1[0] = 10; by1[0] = 10;
        bus1.size = 12'd3; pack1();
        bus1.start = 1'b1;
        @(posedge clk); @(negedge clk);
        bus1.start = 1'b0;
        @(negedge clk);
        chk("busy during op", int'(bus1.busy), 1);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 1500; i++) begin
            if (bus1.done) dcount++;
            @(negedge clk);
        end
        chk("single done pulse", dcount, 1);

        // Reset during the check phase aborts silently
        bus1.start = 1'b1;
        @(posedge clk); @(negedge clk);
        bus1.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("abort busy", int'(bus1.busy), 0);
        chk("abort item_x", int'(bus1.item_x), 12);
        chk("abort item_y", int'(bus1.item_y), 32);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus1.done) dcount++;
            @(negedge clk);
        end
        chk("abort no done", dcount, 0);
        op1("after abort", 3, lat, ox, oy);

        // Randomized starts; half plant the next in-range draw on the body
        for (int r = 0; r < 1000; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int i = 0; i < MS; i++) begin
                bx1[i] = $urandom_range(1, 46);
                by1[i] = $urandom_range(1, 62);
            end
            n = $urandom_range(0, 24);
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                c = m_lfsr;
                for (int g = 0; g < 200; g++) begin
                    c = step(c);
                    if (in_board(int'(c[5:0]), int'(c[11:6]))) break;
                end
                bx1[$urandom_range(0, ((n > MS) ? MS : n) - 1)] = int'(c[5:0]);
                by1[0] = by1[0];
                for (int i = 0; i < MS; i++)
                    if (bx1[i] == int'(c[5:0])) by1[i] = int'(c[11:6]);
            end
            op1($sformatf("rand%0d", r), n, lat, ox, oy);
            bad = (!in_board(ox, oy)) || (body_hit(ox, oy, (n > MS) ? MS : n) >= 0);
            chk($sformatf("rand%0d legal cell", r), bad, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
